pipe_stall_ctrl: RTL and testbench

//   Central stall/flush scheduler for the 5-stage pipeline. Merges the load-use stall and

---
 rtl/pipe_stall_ctrl.sv | 97 +++++++++
 tb/tb_pipe_stall_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline: merges load-use, control-change,
// mul/div latency and data-memory handshake into per-stage stall/flush enables.
module pipe_stall_ctrl #(
   parameter int unsigned MD_CYCLES = 32,
   parameter int unsigned CNT_W     = $clog2(MD_CYCLES) + 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic lwStallD,
   input  logic ctrlChangeE,
   input  logic mdOpE,
   input  logic memReqM,
   input  logic memAckM,
   output logic stallF,
   output logic stallD,
   output logic stallE,
   output logic stallM,
   output logic flushD,
   output logic flushE,
   output logic flushM,
   output logic mdStart,
   output logic mdBusy,
   output logic state
);

   typedef enum logic {
      IDLE   = 1'b0,
      MD_RUN = 1'b1
   } state_e;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic mem_wait;
   logic cnt_zero;
   logic md_issue;
   logic md_busy;
   logic md_hold;
   logic stall_e;
   logic stall_d;

   assign mem_wait = memReqM & ~memAckM;
   assign cnt_zero = (cnt_q == '0);
   assign md_issue = (state_q == IDLE) & mdOpE;
   assign md_busy  = (state_q == MD_RUN) & ~cnt_zero;
   assign md_hold  = md_issue | md_busy;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (mdOpE) begin
               state_d = MD_RUN;
               cnt_d   = CNT_LOAD;
            end
         end
         MD_RUN: begin
            // Once the count is spent, stay parked at zero until M drains so E is not
            // released into a frozen pipeline.
            if (!cnt_zero) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (!mem_wait) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign stall_e = mem_wait | md_hold;
   assign stall_d = stall_e | lwStallD;

   // Outputs are combinational; rst_n gates them so they clear the instant reset asserts.
   assign stallM  = rst_n & mem_wait;
   assign stallE  = rst_n & stall_e;
   assign stallD  = rst_n & stall_d;
   assign stallF  = rst_n & stall_d;
   assign flushM  = rst_n & md_hold & ~mem_wait;
   assign flushE  = rst_n & ~stall_e & (lwStallD | ctrlChangeE);
   assign flushD  = rst_n & ~stall_e & ctrlChangeE;
   assign mdStart = rst_n & md_issue;
   assign mdBusy  = rst_n & md_busy;
   assign state   = rst_n & (state_q == MD_RUN);

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: vector table, hand-written multi-cycle sequences, and random
// stimulus checked against a time-based reference model.
module tb_pipe_stall_ctrl;

   localparam int unsigned MD = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic lw = 1'b0, cc = 1'b0, md = 1'b0, req = 1'b0, ack = 1'b0;
   logic stallF, stallD, stallE, stallM, flushD, flushE, flushM, mdStart, mdBusy, state;
   logic [9:0] outv;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_stall_ctrl #(.MD_CYCLES(MD)) dut (
      .clk(clk), .rst_n(rst_n),
      .lwStallD(lw), .ctrlChangeE(cc), .mdOpE(md), .memReqM(req), .memAckM(ack),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
      .flushD(flushD), .flushE(flushE), .flushM(flushM),
      .mdStart(mdStart), .mdBusy(mdBusy), .state(state)
   );

   // {stallF,stallD,stallE,stallM,flushD,flushE,flushM,mdStart,mdBusy,state}
   assign outv = {stallF, stallD, stallE, stallM, flushD, flushE, flushM, mdStart, mdBusy, state};

   typedef struct packed {
      logic       lw, cc, md, req, ack;
      logic [9:0] exp;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [9:0] got, input logic [9:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %b exp %b", name, got, exp);
      end
   endtask

   // Apply inputs for one cycle at the falling edge; outputs settle 1 time unit later.
   task automatic drive(input logic i_lw, input logic i_cc, input logic i_md,
                        input logic i_req, input logic i_ack);
      @(negedge clk);
      lw = i_lw; cc = i_cc; md = i_md; req = i_req; ack = i_ack;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      lw = 1'b0; cc = 1'b0; md = 1'b0; req = 1'b0; ack = 1'b0;
      #1;
      chk("reset", outv, 10'b0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Reference model: an operation issued at cycle t_issue holds E for cycles
   // t_issue..t_issue+MD-1 and retires in the first cycle >= t_issue+MD without memWait.
   bit in_op;
   int t_issue;

   function automatic logic [9:0] model(input int t, input logic i_lw, input logic i_cc,
                                        input logic i_md, input logic i_req, input logic i_ack);
      logic mw, hold, start, busy, st, se, sd;
      int   e;
      mw = i_req & ~i_ack;
      if (!in_op) begin
         start = i_md; hold = i_md; busy = 1'b0; st = 1'b0;
      end else begin
         e = t - t_issue;
         start = 1'b0; st = 1'b1;
         hold = (e < int'(MD));
         busy = hold;
      end
      se = mw | hold;
      sd = se | i_lw;
      return {sd, sd, se, mw, ~se & i_cc, ~se & (i_lw | i_cc), hold & ~mw, start, busy, st};
   endfunction

   task automatic model_advance(input int t, input logic i_md, input logic i_req, input logic i_ack);
      if (!in_op) begin
         if (i_md) begin
            in_op = 1'b1;
            t_issue = t;
         end
      end else if ((t - t_issue) >= int'(MD) && !(i_req & ~i_ack)) begin
         in_op = 1'b0;
      end
   endtask

   initial begin
      tbl[0]  = '{lw:0, cc:0, md:0, req:0, ack:0, exp:10'b0000000000};
      tbl[1]  = '{lw:1, cc:0, md:0, req:0, ack:0, exp:10'b1100010000};
      tbl[2]  = '{lw:0, cc:1, md:0, req:0, ack:0, exp:10'b0000110000};
      tbl[3]  = '{lw:1, cc:1, md:0, req:0, ack:0, exp:10'b1100110000};
      tbl[4]  = '{lw:0, cc:0, md:0, req:1, ack:0, exp:10'b1111000000};
      tbl[5]  = '{lw:0, cc:0, md:0, req:1, ack:1, exp:10'b0000000000};
      tbl[6]  = '{lw:0, cc:0, md:0, req:0, ack:1, exp:10'b0000000000};
      tbl[7]  = '{lw:0, cc:0, md:1, req:0, ack:0, exp:10'b1110001100};
      tbl[8]  = '{lw:0, cc:0, md:1, req:1, ack:0, exp:10'b1111000100};
      tbl[9]  = '{lw:0, cc:1, md:1, req:0, ack:0, exp:10'b1110001100};
      tbl[10] = '{lw:1, cc:0, md:0, req:1, ack:0, exp:10'b1111000000};
      tbl[11] = '{lw:0, cc:1, md:0, req:1, ack:0, exp:10'b1111000000};

      for (int i = 0; i < 12; i++) begin
         do_reset();
         drive(tbl[i].lw, tbl[i].cc, tbl[i].md, tbl[i].req, tbl[i].ack);
         chk($sformatf("tbl%0d", i), outv, tbl[i].exp);
      end

      // Mul/div issue at cycle 5, hold through 8, retire in 9.
      do_reset();
      for (int c = 0; c < 5; c++) begin
         drive(0, 0, 0, 0, 0);
         chk($sformatf("md_pre%0d", c), outv, 10'b0);
      end
      drive(0, 0, 1, 0, 0);
      chk("md_issue", outv, 10'b1110001100);
      for (int c = 6; c <= 8; c++) begin
         drive(0, 0, 1, 0, 0);
         chk($sformatf("md_run%0d", c), outv, 10'b1110001011);
      end
      drive(0, 0, 1, 0, 0);
      chk("md_last", outv, 10'b0000000001);
      drive(0, 0, 0, 0, 0);
      chk("md_idle", outv, 10'b0);

      // Memory wait cycles 3-5, ack in cycle 6.
      do_reset();
      for (int c = 0; c < 3; c++) drive(0, 0, 0, 0, 0);
      for (int c = 3; c <= 5; c++) begin
         drive(0, 0, 0, 1, 0);
         chk($sformatf("mw%0d", c), outv, 10'b1111000000);
      end
      drive(0, 0, 0, 1, 1);
      chk("mw_ack", outv, 10'b0);

      // Redirect held through a memory wait takes effect on ack.
      do_reset();
      for (int c = 0; c < 2; c++) drive(0, 0, 0, 0, 0);
      for (int c = 2; c <= 3; c++) begin
         drive(0, 1, 0, 1, 0);
         chk($sformatf("cc_wait%0d", c), outv, 10'b1111000000);
      end
      drive(0, 1, 0, 1, 1);
      chk("cc_release", outv, 10'b0000110000);

      // Memory wait overlapping the end of a mul/div: parked at cnt 0, no re-issue.
      do_reset();
      drive(0, 0, 1, 0, 0);
      chk("ov_issue", outv, 10'b1110001100);
      for (int c = 1; c <= 2; c++) begin
         drive(0, 0, 1, 0, 0);
         chk($sformatf("ov_run%0d", c), outv, 10'b1110001011);
      end
      drive(0, 0, 1, 1, 0);
      chk("ov_run3", outv, 10'b1111000011);
      for (int c = 4; c <= 6; c++) begin
         drive(0, 0, 1, 1, 0);
         chk($sformatf("ov_park%0d", c), outv, 10'b1111000001);
      end
      drive(0, 0, 1, 0, 0);
      chk("ov_exit", outv, 10'b0000000001);
      drive(0, 0, 0, 0, 0);
      chk("ov_idle", outv, 10'b0);

      // Asynchronous reset in the middle of an operation, mdOpE kept high.
      do_reset();
      drive(0, 0, 1, 0, 0);
      drive(0, 0, 1, 0, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid", outv, 10'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_reissue", outv, 10'b1110001100);
      for (int c = 1; c <= 3; c++) begin
         drive(0, 0, 1, 0, 0);
         chk($sformatf("rst_run%0d", c), outv, 10'b1110001011);
      end
      drive(0, 0, 1, 0, 0);
      chk("rst_last", outv, 10'b0000000001);

      // Random stimulus against the reference model.
      do_reset();
      in_op = 1'b0;
      t_issue = 0;
      for (int t = 0; t < 3000; t++) begin
         logic r_lw, r_cc, r_md, r_req, r_ack;
         logic [9:0] exp;
         r_lw  = ($urandom_range(0, 3) == 0);
         r_cc  = ($urandom_range(0, 3) == 0);
         r_md  = ($urandom_range(0, 5) == 0);
         r_req = ($urandom_range(0, 1) == 0);
         r_ack = ($urandom_range(0, 1) == 0);
         drive(r_lw, r_cc, r_md, r_req, r_ack);
         exp = model(t, r_lw, r_cc, r_md, r_req, r_ack);
         chk($sformatf("rand%0d", t), outv, exp);
         model_advance(t, r_md, r_req, r_ack);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
